branch_predictor: RTL and testbench

Direct-mapped branch history table with a branch target buffer and 2-bit saturating counters, placed in the fetch stage. Each cycle it looks up the fetch PC and produces the taken prediction (`pred_taken`) and the predicted next PC. These travel down the pipeline as the `branchTaken` input of the control unit. When a conditional branch resolves in decode, the pipeline writes the actual outcome back through the update port.

---
 rtl/bp_pkg.sv | 17 +
 rtl/bp_sat_counter.sv | 24 ++
 rtl/branch_predictor.sv | 100 ++++++++++
 tb/tb_branch_predictor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared constants for the fetch-stage branch predictor: counter encodings
// and instruction size.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    localparam ctr_t CTR_RESET = CTR_WNT;
    localparam ctr_t CTR_ALLOC = CTR_WT;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/bp_sat_counter.sv
// Two-bit saturating counter step: moves toward taken/not-taken and holds
// at either end.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t ctr_q,
    input  logic taken,
    output ctr_t ctr_d
);

    always_comb begin
        ctr_d = ctr_q;
        if (taken) begin
            if (ctr_q != CTR_ST) begin
                ctr_d = ctr_q + 2'd1;
            end
        end else begin
            if (ctr_q != CTR_SNT) begin
                ctr_d = ctr_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB with 2-bit counters: combinational lookup of the
// fetch PC and single-port update from branch resolution.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned PC_W  = 64,
    parameter int unsigned IDX_W = 4
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_next_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    ctr_t             ctr_q    [DEPTH];
    logic [PC_W-1:0]  target_q [DEPTH];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    ctr_t             u_ctr_step;

    logic             wr_en;
    ctr_t             wr_ctr_d;
    logic [PC_W-1:0]  wr_target_d;

    // Byte-offset bits never reach the table.
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    // Lookup path, zero latency.
    always_comb begin
        f_idx        = fetch_pc[IDX_W+1:2];
        f_tag        = fetch_pc[PC_W-1:IDX_W+2];
        f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken   = f_hit && ctr_q[f_idx][1];
        pred_next_pc = pred_taken ? target_q[f_idx]
                                  : fetch_pc + PC_W'(INSTR_BYTES);
    end

    bp_sat_counter u_sat_counter (
        .ctr_q (ctr_q[u_idx]),
        .taken (upd_taken),
        .ctr_d (u_ctr_step)
    );

    // Update decode: train on hit, allocate only on a taken miss.
    always_comb begin
        u_idx       = upd_pc[IDX_W+1:2];
        u_tag       = upd_pc[PC_W-1:IDX_W+2];
        u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        wr_en       = 1'b0;
        wr_ctr_d    = ctr_q[u_idx];
        wr_target_d = target_q[u_idx];
        if (upd_valid) begin
            if (u_hit) begin
                wr_en    = 1'b1;
                wr_ctr_d = u_ctr_step;
                if (upd_taken) begin
                    wr_target_d = upd_target;
                end
            end else if (upd_taken) begin
                wr_en       = 1'b1;
                wr_ctr_d    = CTR_ALLOC;
                wr_target_d = upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i]    <= '0;
                ctr_q[i]    <= CTR_RESET;
                target_q[i] <= '0;
            end
        end else if (wr_en) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            ctr_q[u_idx]    <= wr_ctr_d;
            target_q[u_idx] <= wr_target_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: lookup, training,
// aliasing, same-cycle ordering, PC wrap and asynchronous reset.
module tb_branch_predictor;

    localparam int unsigned PC_W  = 64;
    localparam int unsigned IDX_W = 4;

    logic            clk;
    logic            arst_n;
    logic [PC_W-1:0] fetch_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_next_pc;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;

    int errors = 0;
    int checks = 0;

    branch_predictor #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .fetch_pc     (fetch_pc),
        .pred_taken   (pred_taken),
        .pred_next_pc (pred_next_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one update for a single cycle; idle upd_* inputs are left as X.
    task automatic do_update(input logic [63:0] pc, input logic taken, input logic [63:0] tgt);
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        @(posedge clk);
        #1;
        upd_valid  = 1'b0;
        upd_pc     = 'x;
        upd_taken  = 1'bx;
        upd_target = 'x;
    endtask

    task automatic lookup(input string tag, input logic [63:0] pc,
                          input logic exp_taken, input logic [63:0] exp_next);
        fetch_pc = pc;
        #1;
        check({tag, ".taken"}, 64'(pred_taken), 64'(exp_taken));
        check({tag, ".next"}, pred_next_pc, exp_next);
    endtask

    initial begin
        arst_n     = 1'b0;
        fetch_pc   = 64'h100;
        upd_valid  = 1'b0;
        upd_pc     = 'x;
        upd_taken  = 1'bx;
        upd_target = 'x;

        lookup("reset", 64'h100, 1'b0, 64'h104);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        lookup("post_reset", 64'h100, 1'b0, 64'h104);

        // Allocate taken -> WT
        do_update(64'h100, 1'b1, 64'h80);
        lookup("alloc", 64'h100, 1'b1, 64'h80);

        // WT -> WNT -> SNT -> SNT (low saturation)
        do_update(64'h100, 1'b0, 64'h0);
        lookup("nt1_wnt", 64'h100, 1'b0, 64'h104);
        do_update(64'h100, 1'b0, 64'h0);
        lookup("nt2_snt", 64'h100, 1'b0, 64'h104);
        do_update(64'h100, 1'b0, 64'h0);
        lookup("nt3_snt", 64'h100, 1'b0, 64'h104);

        // SNT -> WNT -> WT -> ST -> ST (high saturation), target follows
        do_update(64'h100, 1'b1, 64'h90);
        lookup("t1_wnt", 64'h100, 1'b0, 64'h104);
        do_update(64'h100, 1'b1, 64'h94);
        lookup("t2_wt", 64'h100, 1'b1, 64'h94);
        do_update(64'h100, 1'b1, 64'h98);
        lookup("t3_st", 64'h100, 1'b1, 64'h98);
        do_update(64'h100, 1'b1, 64'h98);
        lookup("t4_st", 64'h100, 1'b1, 64'h98);

        // ST -> WT keeps target, WT -> WNT drops prediction
        do_update(64'h100, 1'b0, 64'hdead);
        lookup("st_nt_wt", 64'h100, 1'b1, 64'h98);
        do_update(64'h100, 1'b0, 64'hdead);
        lookup("wt_nt_wnt", 64'h100, 1'b0, 64'h104);

        // Aliasing at index 0
        do_update(64'h100, 1'b1, 64'h80);
        lookup("alias_own", 64'h100, 1'b1, 64'h80);
        lookup("alias_miss", 64'h140, 1'b0, 64'h144);
        do_update(64'h140, 1'b1, 64'h200);
        lookup("alias_new", 64'h140, 1'b1, 64'h200);
        lookup("alias_evict", 64'h100, 1'b0, 64'h104);

        // Not-taken miss does not allocate or disturb the resident entry
        do_update(64'h300, 1'b0, 64'h500);
        lookup("nt_miss", 64'h300, 1'b0, 64'h304);
        lookup("nt_miss_keep", 64'h140, 1'b1, 64'h200);

        // Same-cycle lookup and update: pre-update contents are seen
        do_update(64'h100, 1'b1, 64'h80);
        @(negedge clk);
        fetch_pc   = 64'h100;
        upd_valid  = 1'b1;
        upd_pc     = 64'h100;
        upd_taken  = 1'b0;
        upd_target = 64'h0;
        #1;
        check("same_cyc.taken", 64'(pred_taken), 64'd1);
        check("same_cyc.next", pred_next_pc, 64'h80);
        @(posedge clk);
        #1;
        upd_valid  = 1'b0;
        upd_pc     = 'x;
        upd_taken  = 1'bx;
        upd_target = 'x;
        lookup("after_same", 64'h100, 1'b0, 64'h104);
        do_update(64'h100, 1'b1, 64'h84);
        lookup("wnt_to_wt", 64'h100, 1'b1, 64'h84);

        // PC wrap on a miss
        lookup("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);

        // Another index is independent
        do_update(64'h104, 1'b1, 64'h400);
        lookup("idx1", 64'h104, 1'b1, 64'h400);
        lookup("idx0_kept", 64'h100, 1'b1, 64'h84);

        // Asynchronous reset mid-cycle clears everything immediately
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        lookup("async_rst0", 64'h100, 1'b0, 64'h104);
        lookup("async_rst1", 64'h104, 1'b0, 64'h108);
        @(negedge clk);
        arst_n = 1'b1;
        lookup("rst_rel", 64'h140, 1'b0, 64'h144);

        // First edge after reset accepts an update
        do_update(64'h3C, 1'b1, 64'h1234);
        lookup("post_rst_alloc", 64'h3C, 1'b1, 64'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
